// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - data-memory access stage: req/ack load/store with timeout, writeback presentation
module mem_access_stage #(
    parameter int TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_in,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [31:0] addr_in,
    input  logic [31:0] store_data_in,
    input  logic [31:0] result_in,
    input  logic [3:0]  rd_in,
    input  logic        wb_en_in,
    input  logic        flush,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        stall,
    output logic [31:0] instr_out,
    output logic [3:0]  rd_out,
    output logic [31:0] wb_data,
    output logic        wb_en,
    output logic        bus_err
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [31:0] NOP = 32'hE320F000;
    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_ACCESS = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   instr_q, instr_d;
    logic          load_q, load_d;
    logic          store_q, store_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   result_q, result_d;
    logic [3:0]    rd_q, rd_d;
    logic          wben_q, wben_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        instr_d  = instr_q;
        load_d   = load_q;
        store_d  = store_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        result_d = result_q;
        rd_d     = rd_q;
        wben_d   = wben_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                instr_d  = flush ? NOP : instr_in;
                load_d   = is_load & ~flush;
                store_d  = is_store & ~flush;
                addr_d   = addr_in;
                wdata_d  = store_data_in;
                result_d = result_in;
                rd_d     = rd_in;
                wben_d   = wb_en_in & ~flush;
                err_d    = 1'b0;
                if (load_d | store_d) begin
                    state_d = S_ACCESS;
                    cnt_d   = '0;
                end
            end
            S_ACCESS: begin
                // An ack on the last allowed cycle takes priority over the timeout.
                if (mem_ack) begin
                    if (load_q) rdata_d = mem_rdata;
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                    wben_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            instr_q  <= NOP;
            load_q   <= 1'b0;
            store_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            result_q <= '0;
            rd_q     <= '0;
            wben_q   <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            instr_q  <= instr_d;
            load_q   <= load_d;
            store_q  <= store_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            result_q <= result_d;
            rd_q     <= rd_d;
            wben_q   <= wben_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    logic in_access;
    assign in_access = (state_q == S_ACCESS);

    assign stall     = in_access;
    assign mem_req   = in_access;
    assign mem_we    = in_access & store_q & ~load_q;
    assign mem_addr  = in_access ? addr_q : 32'd0;
    assign mem_wdata = in_access ? wdata_q : 32'd0;
    assign instr_out = in_access ? NOP : instr_q;
    assign rd_out    = rd_q;
    assign wb_data   = load_q ? rdata_q : result_q;
    assign wb_en     = wben_q & ~in_access;
    assign bus_err   = err_q & ~in_access;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - self-checking bench for mem_access_stage (TIMEOUT=4)
module tb_mem_access_stage;

    localparam int TO = 4;
    localparam logic [31:0] NOP = 32'hE320F000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr_in, addr_in, store_data_in, result_in, mem_rdata;
    logic        is_load, is_store, wb_en_in, flush, mem_ack;
    logic [3:0]  rd_in;
    logic        mem_req, mem_we, stall, wb_en, bus_err;
    logic [31:0] mem_addr, mem_wdata, instr_out, wb_data;
    logic [3:0]  rd_out;

    int total = 0;
    int bad = 0;

    mem_access_stage #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .instr_in(instr_in), .is_load(is_load), .is_store(is_store),
        .addr_in(addr_in), .store_data_in(store_data_in), .result_in(result_in),
        .rd_in(rd_in), .wb_en_in(wb_en_in), .flush(flush),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .stall(stall), .instr_out(instr_out), .rd_out(rd_out),
        .wb_data(wb_data), .wb_en(wb_en), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic        ld, st, fl;
        logic [31:0] addr, wdata, result;
        logic [3:0]  rd;
        logic        wben;
        int          ack_at;
        logic [31:0] rdata;
        int          exp_acc;
        logic        exp_we;
        logic [31:0] exp_instr, exp_wb;
        logic        exp_wben, exp_err, exp_chk_wb;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] instr, input logic ld, input logic st, input logic fl,
                                input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] result,
                                input logic [3:0] rd, input logic wben, input int ack_at, input logic [31:0] rdata,
                                input int exp_acc, input logic exp_we, input logic [31:0] exp_instr,
                                input logic [31:0] exp_wb, input logic exp_wben, input logic exp_err,
                                input logic exp_chk_wb);
        vec_t v;
        v.instr = instr; v.ld = ld; v.st = st; v.fl = fl;
        v.addr = addr; v.wdata = wdata; v.result = result; v.rd = rd; v.wben = wben;
        v.ack_at = ack_at; v.rdata = rdata;
        v.exp_acc = exp_acc; v.exp_we = exp_we; v.exp_instr = exp_instr; v.exp_wb = exp_wb;
        v.exp_wben = exp_wben; v.exp_err = exp_err; v.exp_chk_wb = exp_chk_wb;
        return v;
    endfunction

    // Transaction-level reference: a memory op occupies the bus until its ack or TIMEOUT cycles.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        logic mem_op = ~v.fl & (v.ld | v.st);
        logic acked = (v.ack_at >= 1) && (v.ack_at <= TO);
        logic tmo = mem_op & ~acked;
        r.exp_acc    = !mem_op ? 0 : (acked ? v.ack_at : TO);
        r.exp_we     = v.st & ~v.ld;
        r.exp_instr  = v.fl ? NOP : v.instr;
        r.exp_wb     = (~v.fl & v.ld) ? v.rdata : v.result;
        r.exp_chk_wb = !(tmo && v.ld);
        r.exp_wben   = ~v.fl & v.wben & ~tmo;
        r.exp_err    = tmo;
        return r;
    endfunction

    // Called at a negedge with the DUT in IDLE; returns at the negedge of the result cycle.
    task automatic apply(input vec_t v);
        instr_in = v.instr; is_load = v.ld; is_store = v.st; flush = v.fl;
        addr_in = v.addr; store_data_in = v.wdata; result_in = v.result;
        rd_in = v.rd; wb_en_in = v.wben;
        mem_ack = 1'($urandom); mem_rdata = $urandom;
        @(negedge clk);
        for (int c = 1; c <= v.exp_acc; c++) begin
            check("acc_stall", 32'(stall), 32'd1);
            check("acc_req", 32'(mem_req), 32'd1);
            check("acc_we", 32'(mem_we), 32'(v.exp_we));
            check("acc_addr", mem_addr, v.addr);
            if (v.exp_we) check("acc_wdata", mem_wdata, v.wdata);
            check("acc_instr", instr_out, NOP);
            check("acc_wben", 32'(wb_en), 32'd0);
            instr_in = $urandom; addr_in = $urandom; store_data_in = $urandom;
            result_in = $urandom; rd_in = 4'($urandom); flush = 1'b1;
            is_load = 1'($urandom); is_store = 1'($urandom); wb_en_in = 1'($urandom);
            mem_ack = (c == v.ack_at);
            mem_rdata = (c == v.ack_at) ? v.rdata : $urandom;
            @(negedge clk);
        end
        mem_ack = 1'($urandom);
        check("out_stall", 32'(stall), 32'd0);
        check("out_req", 32'(mem_req), 32'd0);
        check("out_instr", instr_out, v.exp_instr);
        check("out_rd", 32'(rd_out), 32'(v.rd));
        if (v.exp_chk_wb) check("out_wbdata", wb_data, v.exp_wb);
        check("out_wben", 32'(wb_en), 32'(v.exp_wben));
        check("out_buserr", 32'(bus_err), 32'(v.exp_err));
    endtask

    vec_t tbl [9];
    vec_t rv;

    initial begin
        rst = 1'b1;
        instr_in = NOP; is_load = 0; is_store = 0; addr_in = 0; store_data_in = 0;
        result_in = 0; rd_in = 0; wb_en_in = 0; flush = 0; mem_ack = 0; mem_rdata = 0;

        tbl[0] = mk(32'hE0810002, 0, 0, 0, 32'h0, 32'h0, 32'h1234, 4'd3, 1, 0, 32'h0,
                    0, 0, 32'hE0810002, 32'h1234, 1, 0, 1);
        tbl[1] = mk(32'hE5910000, 1, 0, 0, 32'h100, 32'h0, 32'h55, 4'd5, 1, 3, 32'hDEADBEEF,
                    3, 0, 32'hE5910000, 32'hDEADBEEF, 1, 0, 1);
        tbl[2] = mk(32'hE5810000, 0, 1, 0, 32'h40, 32'hA5A5A5A5, 32'h77, 4'd1, 1, 1, 32'h0,
                    1, 1, 32'hE5810000, 32'h77, 1, 0, 1);
        tbl[3] = mk(32'hE5920000, 1, 0, 0, 32'h200, 32'h0, 32'h9, 4'd7, 1, 0, 32'h0,
                    4, 0, 32'hE5920000, 32'h0, 0, 1, 0);
        tbl[4] = mk(32'hE5930000, 1, 0, 0, 32'h204, 32'h0, 32'h9, 4'd8, 1, 4, 32'hCAFEF00D,
                    4, 0, 32'hE5930000, 32'hCAFEF00D, 1, 0, 1);
        tbl[5] = mk(32'hE5940000, 1, 0, 1, 32'h300, 32'h0, 32'h66, 4'd2, 1, 1, 32'h11111111,
                    0, 0, NOP, 32'h66, 0, 0, 1);
        tbl[6] = mk(32'hE5950000, 1, 1, 0, 32'h44, 32'h12345678, 32'h3, 4'd4, 1, 2, 32'h87654321,
                    2, 0, 32'hE5950000, 32'h87654321, 1, 0, 1);
        tbl[7] = mk(32'hE5840000, 0, 1, 0, 32'h48, 32'h0F0F0F0F, 32'h5, 4'd6, 0, 5, 32'h0,
                    4, 1, 32'hE5840000, 32'h5, 0, 1, 1);
        tbl[8] = mk(32'hE1A00000, 0, 0, 0, 32'h0, 32'h0, 32'hFFFFFFFF, 4'd15, 0, 0, 32'h0,
                    0, 0, 32'hE1A00000, 32'hFFFFFFFF, 0, 0, 1);

        @(negedge clk);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_instr", instr_out, NOP);
        check("rst_wbdata", wb_data, 32'd0);
        check("rst_rd", 32'(rd_out), 32'd0);
        check("rst_wben", 32'(wb_en), 32'd0);
        check("rst_buserr", 32'(bus_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) apply(tbl[i]);

        // Reset asserted in the middle of a load transaction.
        instr_in = 32'hE5960000; is_load = 1; is_store = 0; flush = 0;
        addr_in = 32'h500; wb_en_in = 1; rd_in = 4'd9; mem_ack = 0;
        @(negedge clk);
        check("mid_req_before", 32'(mem_req), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_req", 32'(mem_req), 32'd0);
        check("mid_rst_stall", 32'(stall), 32'd0);
        check("mid_rst_instr", instr_out, NOP);
        check("mid_rst_wben", 32'(wb_en), 32'd0);
        check("mid_rst_wbdata", wb_data, 32'd0);
        check("mid_rst_rd", 32'(rd_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        is_load = 0; instr_in = 32'hE0822003; result_in = 32'hABCD; rd_in = 4'd2; wb_en_in = 1;
        mem_ack = 1;
        @(negedge clk);
        check("post_rst_stall", 32'(stall), 32'd0);
        check("post_rst_req", 32'(mem_req), 32'd0);
        check("post_rst_instr", instr_out, 32'hE0822003);
        check("post_rst_wbdata", wb_data, 32'hABCD);

        for (int i = 0; i < 60; i++) begin
            rv.instr = $urandom; rv.ld = 1'($urandom); rv.st = 1'($urandom);
            rv.fl = ($urandom_range(0, 3) == 0);
            rv.addr = $urandom; rv.wdata = $urandom; rv.result = $urandom;
            rv.rd = 4'($urandom); rv.wben = 1'($urandom);
            rv.ack_at = $urandom_range(0, TO + 1); rv.rdata = $urandom;
            apply(model(rv));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Data-memory access stage of the pipelined ARM32 core, sitting directly downstream of `memory_pipeline_unit`. It consumes the decoded, NOP-substituted instruction and the controller-supplied address, store data and ALU result. For LDR/STR it runs a req/ack transaction with data memory, stalling upstream until the transaction completes or times out. It then presents the instruction, destination register and writeback data to the writeback stage.

## Interface
- `TIMEOUT`, 256: maximum number of ACCESS cycles before a transaction is aborted. Must be ≥1.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `instr_in` in 32: instruction from `memory_pipeline_unit.instr_output`.
- `is_load`, `is_store` in 1 each: controller decode for `instr_in`.
- `addr_in` in 32: effective address.
- `store_data_in` in 32: STR data.
- `result_in` in 32: ALU result, used as writeback data for non-loads.
- `rd_in` in 4: destination register.
- `wb_en_in` in 1: register-write enable for the instruction.
- `flush` in 1: squash the instruction being captured.
- `mem_req` out 1, `mem_we` out 1, `mem_addr` out 32, `mem_wdata` out 32: data-memory request.
- `mem_ack` in 1, `mem_rdata` in 32: memory response, sampled at the rising edge.
- `stall` out 1: upstream must hold its registers.
- `instr_out` out 32, `rd_out` out 4, `wb_data` out 32, `wb_en` out 1: writeback-stage inputs.
- `bus_err` out 1: one-cycle pulse on timeout abort.

## Operation
- Registered slot holds instr_q, load_q, store_q, addr_q, wdata_q, result_q, rd_q, wben_q, rdata_q, err_q.
- Two-state FSM: IDLE and ACCESS.
- **IDLE, each edge:** capture all inputs into the slot.
  - If `flush`=1: instr_q<=NOP (0xE320F000), load_q=store_q=wben_q=0.
  - If the captured load_q|store_q=1, go to ACCESS and clear the counter. Otherwise stay IDLE.
  - err_q<=0.
- **`is_load` and `is_store` both 1:** load wins and `mem_we`=0.
- **ACCESS:**
  - `mem_req`=1, `mem_we`=store_q&~load_q, `mem_addr`=addr_q, `mem_wdata`=wdata_q. All held stable until exit.
  - Slot registers and inputs are not sampled.
  - `flush` is ignored: an in-flight store is never cancelled.
- **ACCESS, edge with `mem_ack`=1:** rdata_q<=`mem_rdata` if load_q; go to IDLE.
- **ACCESS, edge with `mem_ack`=0:**
  - If counter==TIMEOUT-1: go to IDLE, set err_q<=1, wben_q<=0.
  - Otherwise counter+1.
  - Counter width is clog2(TIMEOUT+1) and it never wraps.
- **Outputs:**
  - `stall` = (state==ACCESS), combinational.
  - `instr_out` = NOP in ACCESS, else instr_q.
  - `rd_out` = rd_q.
  - `wb_data` = load_q ? rdata_q : result_q.
  - `wb_en` = wben_q & (state==IDLE).
  - `bus_err` = err_q & (state==IDLE).
  - `mem_req`, `mem_we`, `mem_addr`, `mem_wdata` = 0 in IDLE.
- **Reset (async, any state including mid-ACCESS):**
  - State=IDLE, instr_q=NOP, all other registers 0.
  - Therefore `mem_req`=0, `stall`=0, `instr_out`=NOP, `wb_en`=0, `wb_data`=0, `rd_out`=0, `bus_err`=0.
  - An aborted transaction is not retried.

## Timing
- **Non-memory instruction:** presented on `instr_out` the cycle after capture; 1-cycle latency, no bubble.
- **Memory instruction, ack in the k-th ACCESS cycle (k≥1):**
  - `stall`=1 and `instr_out`=NOP for k cycles.
  - Result presented in the following IDLE cycle.
  - Total latency k+1; k bubbles to writeback.
- **Upstream handoff:** upstream holds its instruction while `stall`=1. That instruction is captured at the edge ending the first IDLE cycle after ACCESS, the same cycle the completed result is on the outputs.
- **Ack on the final allowed cycle (counter==TIMEOUT-1):** ack wins and there is no error.
- **Timeout:** ACCESS lasts exactly TIMEOUT cycles, then `bus_err`=1 for one cycle with `wb_en`=0.
- **`mem_ack` while IDLE:** ignored.

## Test plan
- **Reset:** assert `rst` mid-ACCESS with `mem_req`=1 -> same cycle `mem_req`=0, `stall`=0, `instr_out`=0xE320F000. After release, the FSM is IDLE.
- **ALU pass-through:** ADD, `result_in`=0x1234, `rd_in`=3, `wb_en_in`=1 -> next cycle `instr_out`=ADD, `wb_data`=0x1234, `rd_out`=3, `wb_en`=1, `stall`=0.
- **Load, ack after 3 cycles:** `addr_in`=0x100, `mem_rdata`=0xDEADBEEF on the 3rd ACCESS cycle.
  - `mem_req`=1 with `mem_addr`=0x100 for 3 cycles, `stall`=1 and `instr_out`=NOP throughout.
  - Next cycle `wb_data`=0xDEADBEEF, `wb_en`=1.
  - The following instruction is captured one edge later.
- **Store, immediate ack:** `store_data_in`=0xA5A5A5A5, `addr_in`=0x40 -> exactly one cycle `mem_req`=1, `mem_we`=1, `mem_wdata`=0xA5A5A5A5, then IDLE with `wb_en`=`wb_en_in`.
- **Timeout, TIMEOUT=4:**
  - Load with no ack -> `mem_req` high exactly 4 cycles, then `bus_err`=1 and `wb_en`=0 for one cycle.
  - Repeat with ack on the 4th cycle -> no error, data written back.
- **Flush / priority:**
  - `flush`=1 with a load in IDLE -> no `mem_req`, `instr_out`=NOP next cycle.
  - `flush` during ACCESS of a store -> store completes unchanged.
  - `is_load`=`is_store`=1 -> `mem_we`=0.
